// File: rtl/ecc_operand_loader.sv
// ecc_operand_loader
// Assembles NCH operand words (Px, Py, prime, a, k) from IN_W-bit serial beats
// delivered on all channels in parallel. It also serialises one result word
// back out as IN_W-bit beats. Beat order is LSB-first or MSB-first (MSB_FIRST),
// and the same order is used for loading and unloading.
module ecc_operand_loader #(
    parameter int WORD_W    = 32,
    parameter int IN_W      = 4,
    parameter int NCH       = 5,
    parameter int MSB_FIRST = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_valid,
    input  logic [NCH*IN_W-1:0]    i_data,
    input  logic                   i_abort,
    output logic                   o_ready,
    output logic [NCH*WORD_W-1:0]  o_words,
    output logic                   o_load_done,
    input  logic                   i_res_valid,
    input  logic [WORD_W-1:0]      i_res,
    output logic [IN_W-1:0]        o_res,
    output logic                   o_res_valid,
    output logic                   o_res_last,
    output logic                   o_busy
);

    // WORD_W must be a multiple of IN_W with at least two beats per word.
    localparam int BEATS = WORD_W / IN_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_UNLOAD
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [CNT_W-1:0]    wr_idx;
    logic                load_wr;
    logic                words_clr;
    logic                unl_start;
    logic [WORD_W-1:0]   sreg;
    logic [WORD_W-1:0]   words_q  [NCH];
    logic [WORD_W-1:0]   words_nx [NCH];
    logic [IN_W-1:0]     din      [NCH];

    // Bit position of beat k inside a word, honouring the beat order.
    function automatic int beat_lsb(input logic [CNT_W-1:0] k);
        if (MSB_FIRST != 0) begin
            return (BEATS - 1 - int'(k)) * IN_W;
        end
        return int'(k) * IN_W;
    endfunction

    // Extract beat k of a word.
    function automatic logic [IN_W-1:0] beat_of(input logic [WORD_W-1:0] w,
                                                input logic [CNT_W-1:0]  k);
        logic [WORD_W-1:0] sh;
        sh = w >> beat_lsb(k);
        return sh[IN_W-1:0];
    endfunction

    // Place a beat at position k of an otherwise-zero word.
    function automatic logic [WORD_W-1:0] beat_place(input logic [IN_W-1:0]  b,
                                                     input logic [CNT_W-1:0] k);
        return WORD_W'(b) << beat_lsb(k);
    endfunction

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign din[g]                       = i_data[g*IN_W +: IN_W];
        assign o_words[g*WORD_W +: WORD_W]  = words_q[g];
    end

    // Ready is a pure decode of the state so a beat can be offered without delay.
    assign o_ready = (state == S_IDLE) || (state == S_LOAD);

    // Beat 0 is written from IDLE while the counter is still zero.
    assign wr_idx = (state == S_IDLE) ? '0 : cnt;

    // Next-state, counter and datapath strobes.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        load_wr   = 1'b0;
        words_clr = 1'b0;
        unl_start = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (i_start) begin
                    // Load takes precedence over a simultaneous unload request.
                    state_nx  = S_LOAD;
                    words_clr = 1'b1;
                    load_wr   = 1'b1;
                    cnt_nx    = CNT_W'(1);
                end else if (i_res_valid) begin
                    state_nx  = S_UNLOAD;
                    unl_start = 1'b1;
                end
            end
            S_LOAD: begin
                if (i_abort) begin
                    // Abort discards the partial operands and the beat in flight.
                    state_nx  = S_IDLE;
                    words_clr = 1'b1;
                    cnt_nx    = '0;
                end else if (i_valid) begin
                    load_wr = 1'b1;
                    if (cnt == LAST) begin
                        state_nx = S_DONE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            S_UNLOAD: begin
                if (i_abort || (cnt == LAST)) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Next operand words: optional clear, then OR in the current beat.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            words_nx[c] = words_clr ? '0 : words_q[c];
            if (load_wr) begin
                words_nx[c] = words_nx[c] | beat_place(din[c], wr_idx);
            end
        end
    end

    // State, counter and registered control outputs derived from the next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            o_load_done <= 1'b0;
            o_busy      <= 1'b0;
            o_res_valid <= 1'b0;
            o_res_last  <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            o_load_done <= (state_nx == S_DONE);
            o_busy      <= (state_nx != S_IDLE);
            o_res_valid <= (state_nx == S_UNLOAD);
            o_res_last  <= (state_nx == S_UNLOAD) && (cnt_nx == LAST);
        end
    end

    // Operand words, result shift register and outgoing result beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < NCH; c++) begin
                words_q[c] <= '0;
            end
            sreg  <= '0;
            o_res <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                words_q[c] <= words_nx[c];
            end
            if (unl_start) begin
                sreg <= i_res;
            end
            // The first beat comes straight from i_res since sreg is loaded on the same edge.
            if (state_nx == S_UNLOAD) begin
                o_res <= beat_of(unl_start ? i_res : sreg, cnt_nx);
            end else begin
                o_res <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ecc_operand_loader.sv
// Directed bench for ecc_operand_loader: one LSB-first and one MSB-first
// instance driven from shared stimulus.
module tb_ecc_operand_loader;

    localparam int WORD_W = 32;
    localparam int IN_W   = 4;
    localparam int NCH    = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  valid = 1'b0;
    logic                  abort = 1'b0;
    logic                  res_valid = 1'b0;
    logic [NCH*IN_W-1:0]   data = '0;
    logic [WORD_W-1:0]     res = '0;

    logic                  ready_a, done_a, resv_a, last_a, busy_a;
    logic [NCH*WORD_W-1:0] words_a;
    logic [IN_W-1:0]       res_a;
    logic                  ready_b, done_b, resv_b, last_b, busy_b;
    logic [NCH*WORD_W-1:0] words_b;
    logic [IN_W-1:0]       res_b;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] exp_lsb [8];
    logic [3:0] exp_msb [8];

    ecc_operand_loader #(.WORD_W(WORD_W), .IN_W(IN_W), .NCH(NCH), .MSB_FIRST(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .i_data(data),
        .i_abort(abort), .o_ready(ready_a), .o_words(words_a), .o_load_done(done_a),
        .i_res_valid(res_valid), .i_res(res), .o_res(res_a), .o_res_valid(resv_a),
        .o_res_last(last_a), .o_busy(busy_a)
    );

    ecc_operand_loader #(.WORD_W(WORD_W), .IN_W(IN_W), .NCH(NCH), .MSB_FIRST(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .i_data(data),
        .i_abort(abort), .o_ready(ready_b), .o_words(words_b), .o_load_done(done_b),
        .i_res_valid(res_valid), .i_res(res), .o_res(res_b), .o_res_valid(resv_b),
        .o_res_last(last_b), .o_busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ch(input logic [NCH*WORD_W-1:0] w, input int c);
        logic [NCH*WORD_W-1:0] t;
        t = w >> (c * WORD_W);
        return t[31:0];
    endfunction

    // ch0 = v, ch2 = beat index, ch4 = ~v, other channels zero.
    task automatic put(input logic [3:0] v, input logic [3:0] k);
        data        = '0;
        data[3:0]   = v;
        data[11:8]  = k;
        data[19:16] = ~v;
    endtask

    // Full unstalled load: beat values base, base+1, ... on ch0.
    task automatic load_full(input logic [3:0] base, input logic with_res);
        start     = 1'b1;
        res_valid = with_res;
        put(base, 4'd0);
        step();
        start     = 1'b0;
        res_valid = 1'b0;
        chk("load_busy", 32'(busy_a), 32'h1);
        chk("load_ready", 32'(ready_a), 32'h1);
        for (int k = 1; k < 8; k++) begin
            valid = 1'b1;
            put(base + 4'(k), 4'(k));
            step();
            if (k < 7) chk("done_early", 32'(done_a), 32'h0);
            chk("no_res_valid", 32'(resv_a), 32'h0);
        end
        valid = 1'b0;
        chk("done_a", 32'(done_a), 32'h1);
        chk("done_b", 32'(done_b), 32'h1);
    endtask

    initial begin
        exp_lsb = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
        exp_msb = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF};

        // Reset state
        #12;
        chk("rst_ready", 32'(ready_a), 32'h1);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_resv", 32'(resv_a), 32'h0);
        chk("rst_words", ch(words_a, 0), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Basic load, beats 1..8, done at cycle 8
        load_full(4'h1, 1'b0);
        chk("lsb_ch0", ch(words_a, 0), 32'h87654321);
        chk("lsb_ch2", ch(words_a, 2), 32'h76543210);
        chk("lsb_ch4", ch(words_a, 4), 32'h789ABCDE);
        chk("msb_ch0", ch(words_b, 0), 32'h12345678);
        chk("msb_ch2", ch(words_b, 2), 32'h01234567);
        chk("msb_ch4", ch(words_b, 4), 32'hEDCBA987);
        chk("ch1_zero", ch(words_a, 1), 32'h0);
        // Abort in DONE is ignored; done pulse is single
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("done_single", 32'(done_a), 32'h0);
        chk("idle_busy", 32'(busy_a), 32'h0);
        chk("abort_done_ign", ch(words_a, 0), 32'h87654321);
        // Stray i_valid in IDLE is ignored and words hold
        valid = 1'b1;
        put(4'h9, 4'h9);
        step();
        valid = 1'b0;
        step();
        chk("hold_ch0", ch(words_a, 0), 32'h87654321);
        chk("hold_busy", 32'(busy_a), 32'h0);

        // Unload 0xDEADBEEF
        res_valid = 1'b1;
        res = 32'hDEADBEEF;
        step();
        res_valid = 1'b0;
        res = '0;
        chk("unl_ready", 32'(ready_a), 32'h0);
        chk("unl_busy", 32'(busy_a), 32'h1);
        for (int k = 0; k < 8; k++) begin
            chk("unl_valid", 32'(resv_b), 32'h1);
            chk("unl_msb", 32'(res_b), 32'(exp_msb[k]));
            chk("unl_lsb", 32'(res_a), 32'(exp_lsb[k]));
            chk("unl_last", 32'(last_b), (k == 7) ? 32'h1 : 32'h0);
            step();
        end
        chk("unl_end_valid", 32'(resv_b), 32'h0);
        chk("unl_end_last", 32'(last_b), 32'h0);
        chk("unl_words_hold", ch(words_a, 0), 32'h87654321);

        // Abort at cycle 4 of a load, with i_valid high
        start = 1'b1;
        put(4'h1, 4'h0);
        step();
        start = 1'b0;
        valid = 1'b1;
        for (int k = 1; k < 4; k++) begin
            put(4'(k + 1), 4'(k));
            step();
        end
        abort = 1'b1;
        put(4'h5, 4'h4);
        step();
        abort = 1'b0;
        valid = 1'b0;
        chk("abort_busy", 32'(busy_a), 32'h0);
        chk("abort_done", 32'(done_a), 32'h0);
        chk("abort_words", ch(words_a, 0), 32'h0);
        chk("abort_words4", ch(words_b, 4), 32'h0);
        step();
        chk("abort_no_done", 32'(done_a), 32'h0);
        load_full(4'h9, 1'b0);
        chk("reload_lsb", ch(words_a, 0), 32'h0FEDCBA9);
        chk("reload_msb", ch(words_b, 0), 32'h9ABCDEF0);
        chk("reload_ch4", ch(words_a, 4), 32'hF0123456);
        step();

        // Stalls on cycles 3 and 5 (plus a stray i_start), done at cycle 10
        start = 1'b1;
        put(4'h1, 4'h0);
        step();
        start = 1'b0;
        valid = 1'b1; put(4'h2, 4'h1); step();
        put(4'h3, 4'h2); step();
        valid = 1'b0; start = 1'b1; put(4'hF, 4'h5); step();
        start = 1'b0; valid = 1'b1; put(4'h4, 4'h3); step();
        valid = 1'b0; put(4'hF, 4'h6); step();
        valid = 1'b1; put(4'h5, 4'h4); step();
        put(4'h6, 4'h5); step();
        put(4'h7, 4'h6); step();
        chk("stall_done_c9", 32'(done_a), 32'h0);
        put(4'h8, 4'h7); step();
        valid = 1'b0;
        chk("stall_done_c10", 32'(done_a), 32'h1);
        chk("stall_ch0", ch(words_a, 0), 32'h87654321);
        chk("stall_ch2", ch(words_a, 2), 32'h76543210);
        step();
        chk("stall_done_off", 32'(done_a), 32'h0);

        // i_start together with i_res_valid: load wins, no result beats
        res = 32'hDEADBEEF;
        load_full(4'h9, 1'b1);
        chk("sim_lsb", ch(words_a, 0), 32'h0FEDCBA9);
        step();
        chk("sim_no_resv", 32'(resv_a), 32'h0);
        step();
        chk("sim_no_resv2", 32'(resv_b), 32'h0);

        // Abort during unload
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        step();
        chk("uab_beat1", 32'(res_b), 32'hE);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("uab_resv", 32'(resv_b), 32'h0);
        chk("uab_busy", 32'(busy_b), 32'h0);
        chk("uab_words", ch(words_a, 0), 32'h0FEDCBA9);

        // Async reset at beat 3 of an unload
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        step(); step(); step();
        chk("rb_beat3", 32'(res_b), 32'hD);
        chk("rb_valid", 32'(resv_b), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_resv", 32'(resv_b), 32'h0);
        chk("ar_ready", 32'(ready_b), 32'h1);
        chk("ar_busy", 32'(busy_b), 32'h0);
        chk("ar_res", 32'(res_b), 32'h0);
        chk("ar_words", ch(words_a, 0), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("ar_after_resv", 32'(resv_b), 32'h0);
        chk("ar_after_last", 32'(last_b), 32'h0);
        chk("ar_after_ready", 32'(ready_a), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
